// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with a two-entry output/skid buffer
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t           state;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] skid;
  logic             skid_zero;
  logic             acc;
  logic             drn;
  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;
  // result is formed from the live inputs and captured on the accepting edge
  always_comb begin
    res = a;
    case (op)
      3'b000: res = ~a;
      3'b001: res = a & b;
      3'b010: res = a | b;
      3'b011: res = a ^ b;
      3'b100: res = ~(a & b);
      3'b101: res = ~(a | b);
      3'b110: res = ~(a ^ b);
      default: res = a;
    endcase
  end
  // buffer FSM: output register plus skid register, all handshake outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      skid      <= '0;
      skid_zero <= 1'b0;
      op_count  <= '0;
    end else begin
      if (acc && op_count != '1) op_count <= op_count + CNT_W'(1);
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (acc) begin
            y         <= res;
            zero      <= (res == '0);
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (acc && !drn) begin
            skid      <= res;
            skid_zero <= (res == '0);
            in_ready  <= 1'b0;
            state     <= TWO;
          end else if (acc) begin
            y    <= res;
            zero <= (res == '0);
          end else if (drn) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (drn) begin
            y        <= skid;
            zero     <= skid_zero;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench for logic_unit_pipe
module tb_logic_unit_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  op = '0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        in_ready, out_valid, zero;
  logic [7:0]  y;
  logic [15:0] op_count;
  logic        in_ready_s, out_valid_s, zero_s;
  logic [7:0]  y_s;
  logic [3:0]  op_count_s;
  int          tests = 0;
  int          fails = 0;
  int          exp_cnt = 0;
  logic [7:0]  q[$];
  logic        held = 1'b0;
  logic [7:0]  hy;
  logic        hz;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero), .op_count(op_count)
  );
  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .op(op), .a(a), .b(b),
    .out_valid(out_valid_s), .out_ready(out_ready), .y(y_s), .zero(zero_s), .op_count(op_count_s)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_y(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return ~x;
      3'd1: return x & z;
      3'd2: return x | z;
      3'd3: return x ^ z;
      3'd4: return ~(x & z);
      3'd5: return ~(x | z);
      3'd6: return ~(x ^ z);
      default: return x;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) step;
    chk("drain_timeout", out_valid, 0);
  endtask

  task automatic send1(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z, input logic ez);
    op = o; a = x; b = z; in_valid = 1'b1; out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    chk("zero_y", y, ref_y(o, x, z));
    chk("zero_flag", zero, ez);
    step;
  endtask

  // monitor: track accepts into the queue, pop and compare on every transfer
  always @(negedge clk) begin
    if (rst_n) begin
      chk("op_count", op_count, exp_cnt);
      chk("op_count_sat", op_count_s, exp_cnt > 15 ? 15 : exp_cnt);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          logic [7:0] e;
          e = q.pop_front();
          chk("sb_y", y, e);
          chk("sb_zero", zero, e == 8'h00);
        end
      end
      if (held && out_valid) begin
        chk("hold_y", y, hy);
        chk("hold_zero", zero, hz);
      end
      held = out_valid && !out_ready;
      hy = y;
      hz = zero;
      if (in_valid && in_ready) begin
        q.push_back(ref_y(op, a, b));
        exp_cnt++;
      end
    end else held = 1'b0;
  end

  initial begin
    logic [7:0] tab[8];
    logic [7:0] first;
    int n;
    int cyc;
    tab = '{8'h5A, 8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'hA5};
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_zero", zero, 0);
    chk("rst_op_count", op_count, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step;
    chk("post_rst_in_ready", in_ready, 1);
    // all-ops sweep, one result per cycle
    out_ready = 1'b1;
    a = 8'hA5; b = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i); in_valid = 1'b1;
      step;
      chk("sweep_valid", out_valid, 1);
      chk("sweep_y", y, tab[i]);
    end
    drain;
    chk("sat_partial", op_count_s, 8);
    // backpressure: three attempts, two accepted
    out_ready = 1'b0; in_valid = 1'b1; n = 0;
    first = ref_y(3'd1, 8'h0F, 8'h35);
    for (int i = 0; i < 3; i++) begin
      op = i == 0 ? 3'd1 : 3'($urandom_range(7));
      a = i == 0 ? 8'h0F : 8'($urandom);
      b = i == 0 ? 8'h35 : 8'($urandom);
      if (in_ready) n++;
      step;
    end
    in_valid = 1'b0;
    chk("bp_accepted", n, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_y_first", y, first);
    out_ready = 1'b1;
    step;
    step;
    chk("bp_in_ready_again", in_ready, 1);
    drain;
    // zero flag
    send1(3'd3, 8'hFF, 8'hFF, 1'b1);
    send1(3'd0, 8'hFF, 8'h5A, 1'b1);
    send1(3'd2, 8'h00, 8'h01, 1'b0);
    drain;
    // reset while both entries are occupied
    out_ready = 1'b0; in_valid = 1'b1;
    op = 3'd2; a = 8'h11; b = 8'h22;
    step;
    op = 3'd3; a = 8'h33; b = 8'h0F;
    step;
    in_valid = 1'b0;
    chk("mid_two_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_op_count", op_count, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_sat_count", op_count_s, 0);
    q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step;
    chk("mid_rel_in_ready", in_ready, 1);
    chk("mid_rel_out_valid", out_valid, 0);
    op = 3'd5; a = 8'h81; b = 8'h18; in_valid = 1'b1; out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    chk("mid_new_y", y, 8'h66);
    drain;
    chk("mid_q_empty", q.size(), 0);
    chk("mid_count", op_count, 1);
    // random stress
    n = 0;
    cyc = 0;
    while (n < 1000 && cyc < 20000) begin
      in_valid = ($urandom_range(1) == 1);
      out_ready = ($urandom_range(1) == 1);
      op = 3'($urandom_range(7));
      a = 8'($urandom);
      b = 8'($urandom);
      if (in_valid && in_ready) n++;
      step;
      cyc++;
    end
    chk("rand_accepts", n, 1000);
    drain;
    chk("rand_q_empty", q.size(), 0);
    chk("rand_op_count", op_count, 1001);
    chk("rand_sat", op_count_s, 15);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
